// File: rtl/rx_tune_ctrl.sv
// Retune scheduler for three DDC/DUC channel pairs: round-robin accept, then
// mute -> flush -> load -> settle -> release for the granted channel.
module rx_tune_ctrl #(
    parameter int unsigned FLUSH_CYCLES  = 16,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter logic [15:0] RESET_INC     = 16'h0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  req_valid,
    input  logic [47:0] req_ddc_inc,
    input  logic [47:0] req_duc_inc,
    output logic [2:0]  req_ready,
    output logic [47:0] ddc_phase_inc,
    output logic [47:0] duc_phase_inc,
    output logic [2:0]  dac_mute,
    output logic        busy,
    output logic        done,
    output logic [1:0]  done_ch
);

    localparam int unsigned MAX_CYC = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MUTE    = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [1:0]    rr_q, rr_d;
    logic [1:0]    chan_q, chan_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   ddc_new_q, ddc_new_d;
    logic [15:0]   duc_new_q, duc_new_d;
    logic [47:0]   ddc_q, ddc_d;
    logic [47:0]   duc_q, duc_d;
    logic [2:0]    mute_q, mute_d;

    logic          grant_valid;
    logic [1:0]    grant_ch;

    // Rotating priority search starting at rr_q; only active in IDLE.
    always_comb begin
        int unsigned cand;
        grant_valid = 1'b0;
        grant_ch    = '0;
        cand        = 0;
        if (state_q == S_IDLE) begin
            for (int unsigned i = 0; i < 3; i++) begin
                cand = 32'(rr_q) + i;
                if (cand >= 3) cand = cand - 3;
                if (!grant_valid && req_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_ch    = 2'(cand);
                end
            end
        end
        req_ready = grant_valid ? (3'b001 << grant_ch) : 3'b000;
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        chan_d    = chan_q;
        cnt_d     = cnt_q;
        ddc_new_d = ddc_new_q;
        duc_new_d = duc_new_q;
        ddc_d     = ddc_q;
        duc_d     = duc_q;
        mute_d    = mute_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    ddc_new_d = req_ddc_inc[{grant_ch, 4'b0000} +: 16];
                    duc_new_d = req_duc_inc[{grant_ch, 4'b0000} +: 16];
                    chan_d    = grant_ch;
                    rr_d      = (grant_ch == 2'd2) ? 2'd0 : grant_ch + 2'd1;
                    mute_d    = 3'b001 << grant_ch;
                    cnt_d     = CW'(FLUSH_CYCLES - 1);
                    state_d   = S_MUTE;
                end
            end
            S_MUTE: begin
                if (cnt_q == '0) state_d = S_LOAD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_LOAD: begin
                ddc_d[{chan_q, 4'b0000} +: 16] = ddc_new_q;
                duc_d[{chan_q, 4'b0000} +: 16] = duc_new_q;
                cnt_d   = CW'(SETTLE_CYCLES - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_RELEASE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RELEASE: begin
                mute_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                mute_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            chan_q    <= '0;
            cnt_q     <= '0;
            ddc_new_q <= '0;
            duc_new_q <= '0;
            ddc_q     <= {3{RESET_INC}};
            duc_q     <= {3{RESET_INC}};
            mute_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            chan_q    <= chan_d;
            cnt_q     <= cnt_d;
            ddc_new_q <= ddc_new_d;
            duc_new_q <= duc_new_d;
            ddc_q     <= ddc_d;
            duc_q     <= duc_d;
            mute_q    <= mute_d;
        end
    end

    assign ddc_phase_inc = ddc_q;
    assign duc_phase_inc = duc_q;
    assign dac_mute      = mute_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_RELEASE);
    assign done_ch       = done ? chan_q : 2'd0;

endmodule
